// File: rtl/sr_flag_arbiter.sv
// sr_flag_arbiter: round-robin access to a bank of SR latches.
// One request is accepted at a time. The FSM drives S or R for PULSE_CYC
// cycles, waits one settle cycle, then reads Q back and reports done/done_err.
//
// Handshake: a requester raises req_valid[i] with req_op[i]/req_idx[i] stable
// and holds all three until req_ready[i] pulses for one cycle; the request is
// accepted in that cycle and the requester may drop or replace it right after.
// Every accepted request produces exactly one done[i] pulse, qualified by
// done_err.
//
// All outputs are registered and follow the state of the previous cycle.
// With acceptance visible at cycle T, S/R is high on T+1..T+PULSE_CYC and
// done pulses at T+PULSE_CYC+2. An out-of-range index skips DRIVE/SETTLE and
// completes at T+1 with done_err=1.
module sr_flag_arbiter #(
  parameter int N_REQ     = 4,
  parameter int N_FLAGS   = 8,
  parameter int IDX_W     = 3,
  parameter int PULSE_CYC = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ-1:0]       req_op,
  input  logic [N_REQ*IDX_W-1:0] req_idx,
  output logic [N_REQ-1:0]       req_ready,
  output logic [N_REQ-1:0]       done,
  output logic                   done_err,
  output logic                   busy,
  output logic [N_FLAGS-1:0]     latch_s,
  output logic [N_FLAGS-1:0]     latch_r,
  input  logic [N_FLAGS-1:0]     latch_q
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {IDLE, DRIVE, SETTLE, CHECK} state_t;

  state_t             state, state_nxt;
  logic [PTR_W-1:0]   ptr;
  logic [PTR_W-1:0]   g_sel, g_reg;
  logic               found;
  logic               in_op, in_bad;
  logic [IDX_W-1:0]   in_idx;
  logic               op_reg, bad_reg;
  logic [IDX_W-1:0]   idx_reg;
  logic [3:0]         cnt;
  logic               q_bit;
  logic [N_REQ-1:0]   ready_nxt, done_nxt;
  logic [N_FLAGS-1:0] s_nxt, r_nxt;
  logic               err_nxt;

  // Round-robin pick: lowest valid index at or above ptr, else lowest overall.
  always_comb begin
    found  = 1'b0;
    g_sel  = '0;
    in_op  = 1'b0;
    in_idx = '0;
    for (int j = N_REQ - 1; j >= 0; j--) begin
      if (req_valid[j]) begin
        found = 1'b1;
        g_sel = PTR_W'(j);
      end
    end
    for (int j = N_REQ - 1; j >= 0; j--) begin
      if (req_valid[j] && (PTR_W'(j) >= ptr)) g_sel = PTR_W'(j);
    end
    for (int j = 0; j < N_REQ; j++) begin
      if (g_sel == PTR_W'(j)) begin
        in_op  = req_op[j];
        in_idx = req_idx[j*IDX_W +: IDX_W];
      end
    end
    in_bad = (32'(in_idx) >= N_FLAGS);
  end

  // Next state and next values of the registered outputs.
  always_comb begin
    state_nxt = state;
    ready_nxt = '0;
    done_nxt  = '0;
    s_nxt     = '0;
    r_nxt     = '0;
    err_nxt   = 1'b0;
    q_bit     = 1'b0;
    case (state)
      IDLE: begin
        if (found) begin
          state_nxt = in_bad ? CHECK : DRIVE;
          for (int j = 0; j < N_REQ; j++) begin
            if (g_sel == PTR_W'(j)) ready_nxt[j] = 1'b1;
          end
        end
      end
      DRIVE: begin
        // Only one side of the addressed latch is driven, so S&R never overlap.
        for (int f = 0; f < N_FLAGS; f++) begin
          if (idx_reg == IDX_W'(f)) begin
            s_nxt[f] = op_reg;
            r_nxt[f] = ~op_reg;
          end
        end
        if (cnt == 4'(PULSE_CYC - 1)) state_nxt = SETTLE;
      end
      SETTLE: state_nxt = CHECK;
      CHECK: begin
        state_nxt = IDLE;
        for (int f = 0; f < N_FLAGS; f++) begin
          if (idx_reg == IDX_W'(f)) q_bit = latch_q[f];
        end
        for (int j = 0; j < N_REQ; j++) begin
          if (g_reg == PTR_W'(j)) done_nxt[j] = 1'b1;
        end
        err_nxt = bad_reg | (q_bit != op_reg);
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Capture the granted request, advance the RR pointer, count pulse cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr     <= '0;
      g_reg   <= '0;
      op_reg  <= 1'b0;
      idx_reg <= '0;
      bad_reg <= 1'b0;
      cnt     <= '0;
    end else begin
      if (state == IDLE && found) begin
        g_reg   <= g_sel;
        op_reg  <= in_op;
        idx_reg <= in_idx;
        bad_reg <= in_bad;
        ptr     <= (g_sel == PTR_W'(N_REQ - 1)) ? '0 : g_sel + 1'b1;
      end
      if (state == DRIVE) cnt <= cnt + 4'd1;
      else                cnt <= '0;
    end
  end

  // Registered outputs; async reset drops S/R immediately, even mid-pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_ready <= '0;
      done      <= '0;
      done_err  <= 1'b0;
      latch_s   <= '0;
      latch_r   <= '0;
    end else begin
      req_ready <= ready_nxt;
      done      <= done_nxt;
      done_err  <= err_nxt;
      latch_s   <= s_nxt;
      latch_r   <= r_nxt;
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_sr_flag_arbiter.sv
// Directed bench for sr_flag_arbiter with a behavioural SR latch bank model.
module tb_sr_flag_arbiter;

  localparam int NR = 4;
  localparam int NF = 8;
  localparam int IW = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- main DUT (N_FLAGS=8) ----------------
  logic [NR-1:0]    req_valid = '0, req_op = '0;
  logic [NR*IW-1:0] req_idx = '0;
  logic [NR-1:0]    req_ready, done;
  logic             done_err, busy;
  logic [NF-1:0]    latch_s, latch_r, latch_q;
  logic [NF-1:0]    model_q = 8'h00;
  logic [NF-1:0]    stuck_mask = 8'h00;

  sr_flag_arbiter #(.N_REQ(NR), .N_FLAGS(NF), .IDX_W(IW), .PULSE_CYC(2)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_op(req_op),
    .req_idx(req_idx), .req_ready(req_ready), .done(done), .done_err(done_err),
    .busy(busy), .latch_s(latch_s), .latch_r(latch_r), .latch_q(latch_q)
  );

  // Latch bank model: S sets, R clears, reset never touches it.
  always @(posedge clk) begin
    for (int f = 0; f < NF; f++) begin
      if (latch_s[f])      model_q[f] <= 1'b1;
      else if (latch_r[f]) model_q[f] <= 1'b0;
    end
  end
  assign latch_q = model_q & ~stuck_mask;

  // ---------------- second DUT (N_FLAGS=6) ----------------
  logic [NR-1:0]    v6 = '0, op6 = '0;
  logic [NR*IW-1:0] idx6 = '0;
  logic [NR-1:0]    ready6, done6;
  logic             err6, busy6;
  logic [5:0]       s6, r6;
  logic [5:0]       q6 = 6'h00;

  sr_flag_arbiter #(.N_REQ(NR), .N_FLAGS(6), .IDX_W(IW), .PULSE_CYC(2)) dut6 (
    .clk(clk), .rst_n(rst_n), .req_valid(v6), .req_op(op6),
    .req_idx(idx6), .req_ready(ready6), .done(done6), .done_err(err6),
    .busy(busy6), .latch_s(s6), .latch_r(r6), .latch_q(q6)
  );

  // ---------------- scoreboard state ----------------
  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  logic [1:0] exp_q[$];
  int gr_id[8], gr_cyc[8], dn_id[8];
  logic dn_err[8];
  int n_gr, n_dn, s_cycles;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock; sample 1 time unit after the edge and check invariants.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    check("inv_s_and_r", 32'(latch_s & latch_r), 0);
    check("inv_onehot_sr", 32'($onehot0(latch_s | latch_r)), 1);
    check("inv_onehot_done", 32'($onehot0(done)), 1);
    check("inv_err_qualified", 32'((done == '0) && done_err), 0);
  endtask

  task automatic set_req(input int i, input logic op, input logic [IW-1:0] idx);
    req_op[i]          = op;
    req_idx[i*IW +: IW] = idx;
    req_valid[i]       = 1'b1;
  endtask

  // Run until n_want done pulses, logging grants and completions.
  task automatic collect(input int n_want);
    n_gr = 0; n_dn = 0; s_cycles = 0;
    for (int k = 0; k < 8; k++) begin
      gr_id[k] = 9; gr_cyc[k] = 0; dn_id[k] = 9; dn_err[k] = 1'bx;
    end
    for (int c = 0; c < 80 && n_dn < n_want; c++) begin
      step();
      if (latch_s != '0) s_cycles++;
      for (int i = 0; i < NR; i++) begin
        if (req_ready[i] && n_gr < 8) begin
          gr_id[n_gr] = i; gr_cyc[n_gr] = cyc; n_gr++; req_valid[i] = 1'b0;
        end
        if (done[i] && n_dn < 8) begin
          dn_id[n_dn] = i; dn_err[n_dn] = done_err; n_dn++;
        end
      end
    end
    check("collect_done_count", 32'(n_dn), 32'(n_want));
  endtask

  // Random stress cycle: scoreboard accepts against completions.
  task automatic stress_cycle(input bit allow_new);
    logic [1:0] e;
    step();
    for (int i = 0; i < NR; i++) begin
      if (req_ready[i]) begin
        req_valid[i] = 1'b0;
        exp_q.push_back(2'(i));
      end
    end
    if (done != '0) begin
      if (exp_q.size() == 0) begin
        check("stress_unexpected_done", 32'(done), 0);
      end else begin
        e = exp_q.pop_front();
        check("stress_done_id", 32'(done), 32'(4'b0001 << e));
        check("stress_done_err", 32'(done_err), 0);
      end
    end
    if (allow_new) begin
      for (int i = 0; i < NR; i++) begin
        if (!req_valid[i] && !req_ready[i] && $urandom_range(0, 3) == 0)
          set_req(i, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
      end
    end
  endtask

  initial begin
    // ---- reset state ----
    rst_n = 1'b0;
    step(); step(); step();
    check("rst_ready", 32'(req_ready), 0);
    check("rst_done", 32'(done), 0);
    check("rst_err", 32'(done_err), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_latch_s", 32'(latch_s), 0);
    check("rst_latch_r", 32'(latch_r), 0);
    rst_n = 1'b1;

    // ---- 1: req0 set idx 3, cycle-exact timing ----
    set_req(0, 1'b1, 3'd3);
    step();
    check("t1_ready", 32'(req_ready), 32'h1);
    check("t1_busy", 32'(busy), 1);
    check("t1_s_T", 32'(latch_s), 0);
    req_valid[0] = 1'b0;
    step();
    check("t1_s_T1", 32'(latch_s), 32'h08);
    check("t1_r_T1", 32'(latch_r), 0);
    check("t1_ready_pulse", 32'(req_ready), 0);
    step();
    check("t1_s_T2", 32'(latch_s), 32'h08);
    step();
    check("t1_s_T3", 32'(latch_s), 0);
    check("t1_done_T3", 32'(done), 0);
    check("t1_busy_T3", 32'(busy), 1);
    step();
    check("t1_done_T4", 32'(done), 32'h1);
    check("t1_err_T4", 32'(done_err), 0);
    check("t1_r_T4", 32'(latch_r), 0);
    check("t1_q3", 32'(model_q[3]), 1);
    step();
    check("t1_done_clear", 32'(done), 0);
    check("t1_idle", 32'(busy), 0);

    // Reset between scenarios puts ptr back to 0; latches keep their values.
    rst_n = 1'b0;
    step(); step();
    rst_n = 1'b1;
    check("rst_keeps_latch", 32'(latch_q[3]), 1);

    // ---- 2: all four clear different flags, RR order 0..3, 5 cycles apart ----
    set_req(0, 1'b0, 3'd3); set_req(1, 1'b0, 3'd4);
    set_req(2, 1'b0, 3'd5); set_req(3, 1'b0, 3'd6);
    collect(4);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("t2_grant_id%0d", k), 32'(gr_id[k]), 32'(k));
      check($sformatf("t2_spacing%0d", k), 32'(gr_cyc[k] - gr_cyc[0]), 32'(5 * k));
      check($sformatf("t2_err%0d", k), 32'(dn_err[k]), 0);
    end
    check("t2_q3_cleared", 32'(model_q[3]), 0);

    // ---- 3: ptr=0, req1 and req3 -> req1; then ptr=2 so req3 beats req0 ----
    set_req(1, 1'b1, 3'd1); set_req(3, 1'b1, 3'd2);
    step();
    check("t3_first_grant", 32'(req_ready), 32'h2);
    req_valid[1] = 1'b0;
    set_req(0, 1'b0, 3'd1);
    collect(3);
    check("t3_second_grant", 32'(gr_id[0]), 3);
    check("t3_third_grant", 32'(gr_id[1]), 0);
    check("t3_done0", 32'(dn_id[0]), 1);
    check("t3_done1", 32'(dn_id[1]), 3);
    check("t3_done2", 32'(dn_id[2]), 0);
    check("t3_q1_last", 32'(model_q[1]), 0);
    check("t3_q2_set", 32'(model_q[2]), 1);

    // ---- 4a: Q stuck at 0 on idx 7, set -> done_err ----
    stuck_mask = 8'h80;
    set_req(2, 1'b1, 3'd7);
    collect(1);
    check("t4_grant", 32'(gr_id[0]), 2);
    check("t4_done", 32'(dn_id[0]), 2);
    check("t4_err", 32'(dn_err[0]), 1);
    stuck_mask = 8'h00;

    // ---- set on an already-set flag: full pulse, no error ----
    set_req(1, 1'b1, 3'd0);
    collect(1);
    check("reset_first_err", 32'(dn_err[0]), 0);
    set_req(1, 1'b1, 3'd0);
    collect(1);
    check("reset_again_pulse", 32'(s_cycles), 2);
    check("reset_again_err", 32'(dn_err[0]), 0);
    check("reset_again_q", 32'(model_q[0]), 1);

    // ---- same flag from two requesters (ptr=2): 0 then 1, last wins ----
    set_req(0, 1'b0, 3'd6); set_req(1, 1'b1, 3'd6);
    collect(2);
    check("same_flag_first", 32'(gr_id[0]), 0);
    check("same_flag_second", 32'(gr_id[1]), 1);
    check("same_flag_q6", 32'(model_q[6]), 1);

    // ---- 4b: N_FLAGS=6 build, idx 7 -> no S/R, done at T+1 with err ----
    op6[2] = 1'b1; idx6[2*IW +: IW] = 3'd7; v6[2] = 1'b1;
    step();
    check("t4b_ready", 32'(ready6), 32'h4);
    check("t4b_busy", 32'(busy6), 1);
    check("t4b_sr_T", 32'(s6 | r6), 0);
    v6[2] = 1'b0;
    step();
    check("t4b_done", 32'(done6), 32'h4);
    check("t4b_err", 32'(err6), 1);
    check("t4b_sr_T1", 32'(s6 | r6), 0);
    step();
    check("t4b_done_clear", 32'(done6), 0);
    check("t4b_idle", 32'(busy6), 0);

    // ---- 5: reset mid-DRIVE of a set on idx 5 ----
    set_req(2, 1'b1, 3'd5);
    step();
    check("t5_ready", 32'(req_ready), 32'h4);
    req_valid[2] = 1'b0;
    step();
    check("t5_driving", 32'(latch_s), 32'h20);
    rst_n = 1'b0;
    #1;
    check("t5_s_async", 32'(latch_s), 0);
    check("t5_busy_async", 32'(busy), 0);
    step(); step();
    rst_n = 1'b1;
    set_req(0, 1'b1, 3'd4); set_req(1, 1'b1, 3'd5);
    step();
    check("t5_ptr0_wins", 32'(req_ready), 32'h1);
    req_valid[0] = 1'b0;
    collect(2);
    check("t5_next_grant", 32'(gr_id[0]), 1);
    check("t5_done_a", 32'(dn_id[0]), 0);
    check("t5_done_b", 32'(dn_id[1]), 1);

    // ---- 6: random stress, then drain ----
    exp_q.delete();
    for (int c = 0; c < 2000; c++) stress_cycle(1'b1);
    for (int c = 0; c < 300 && (req_valid != '0 || busy || exp_q.size() != 0); c++)
      stress_cycle(1'b0);
    check("stress_pending", 32'(exp_q.size()), 0);
    check("stress_valid_drained", 32'(req_valid), 0);
    check("stress_idle", 32'(busy), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
